// File: rtl/regfile_wb_arbiter.sv
// Two-port (ALU / load) writeback arbiter feeding the single regfile write port.
// Round-robin grant into a one-entry registered stage; writes to r0 are dropped and counted.
module regfile_wb_arbiter #(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      a_valid,
    input  logic [ADDR_W-1:0]         a_dest,
    input  logic [DATA_W-1:0]         a_data,
    output logic                      a_ready,
    input  logic                      b_valid,
    input  logic [ADDR_W-1:0]         b_dest,
    input  logic [DATA_W-1:0]         b_data,
    output logic                      b_ready,
    input  logic                      hold,
    output logic                      rf_write_en,
    output logic [ADDR_W-1:0]         rf_write_dest,
    output logic [DATA_W-1:0]         rf_write_data,
    output logic [(1<<ADDR_W)-1:0]    pending_mask,
    output logic [CNT_W-1:0]          zero_drop_cnt
);

    localparam int                NREG    = 1 << ADDR_W;
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;

    logic                 r_stage_valid;
    logic [ADDR_W-1:0]    r_stage_dest;
    logic [DATA_W-1:0]    r_stage_data;
    logic                 r_rr_last;
    logic [CNT_W-1:0]     r_zero_cnt;

    logic                 w_can_load;
    logic                 w_grant_a;
    logic                 w_grant_b;
    logic                 w_hs_a;
    logic                 w_hs_b;
    logic                 w_hs;
    logic                 w_drain;
    logic [ADDR_W-1:0]    w_hs_dest;
    logic [DATA_W-1:0]    w_hs_data;
    logic                 w_hs_zero;
    logic [NREG-1:0]      w_mask;

    // Ties go to the port that did not win last; a lone requester always wins.
    always_comb begin
        w_can_load = ~r_stage_valid | ~hold;
        w_grant_a  = a_valid & (~b_valid | r_rr_last);
        w_grant_b  = b_valid & ~w_grant_a;
        w_hs_a     = rst & w_can_load & w_grant_a;
        w_hs_b     = rst & w_can_load & w_grant_b;
        w_hs       = w_hs_a | w_hs_b;
        w_hs_dest  = w_hs_b ? b_dest : a_dest;
        w_hs_data  = w_hs_b ? b_data : a_data;
        w_hs_zero  = (w_hs_dest == '0);
        w_drain    = r_stage_valid & ~hold;
    end

    always_comb begin
        w_mask = '0;
        if (r_stage_valid)
            w_mask[r_stage_dest] = 1'b1;
    end

    // Reset also blocks the write-enable so an in-flight entry never commits.
    assign a_ready       = w_hs_a;
    assign b_ready       = w_hs_b;
    assign rf_write_en   = rst & w_drain;
    assign rf_write_dest = r_stage_dest;
    assign rf_write_data = r_stage_data;
    assign pending_mask  = w_mask;
    assign zero_drop_cnt = r_zero_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stage_valid <= 1'b0;
            r_stage_dest  <= '0;
            r_stage_data  <= '0;
            r_rr_last     <= 1'b1;
            r_zero_cnt    <= '0;
        end else begin
            if (w_drain)
                r_stage_valid <= 1'b0;
            if (w_hs) begin
                r_rr_last <= w_hs_b;
                if (!w_hs_zero) begin
                    r_stage_valid <= 1'b1;
                    r_stage_dest  <= w_hs_dest;
                    r_stage_data  <= w_hs_data;
                end else if (r_zero_cnt != CNT_MAX) begin
                    r_zero_cnt <= r_zero_cnt + 1'b1;
                end
            end
        end
    end

endmodule
